secuenciador_rtc: RTL

SECUENCIADOR_RTC -- requirements
Module: secuenciador_rtc

---
 rtl/secuenciador_rtc.sv | 64 ++++++
 1 files changed

// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: multiplexed A/D bus sequencer, 15 timed states per read/write transaction
module secuenciador_rtc #(
    parameter int unsigned CICLOS_POR_ESTADO = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       W_R,
    input  logic [7:0] direccion,
    input  logic [7:0] dato_escritura,
    input  logic [7:0] bus_dato_in,
    output logic [3:0] estado,
    output logic       W_R_out,
    output logic       en_out,
    output logic [7:0] bus_dato_out,
    output logic       bus_oe,
    output logic [7:0] dato_leido,
    output logic       ocupado,
    output logic       listo
);
    localparam logic [7:0] ULTIMO = 8'(CICLOS_POR_ESTADO - 1);
    logic [7:0] cnt, dir_l, dat_l;
    logic       wr_l, fin, fase_dir, fase_dat;
    assign fin = cnt == ULTIMO;
    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= 4'd15;
            cnt        <= 8'd0;
            wr_l       <= 1'b0;
            dir_l      <= 8'd0;
            dat_l      <= 8'd0;
            dato_leido <= 8'd0;
            listo      <= 1'b0;
        end else begin
            listo <= 1'b0;
            if (estado == 4'd15) begin
                if (inicio) begin
                    wr_l   <= W_R;
                    dir_l  <= direccion;
                    dat_l  <= dato_escritura;
                    estado <= 4'd0;
                    cnt    <= 8'd0;
                end
            end else if (!fin) begin
                cnt <= cnt + 8'd1;
            end else begin
                // state 14 wraps to idle (15) through the plain increment
                cnt    <= 8'd0;
                estado <= estado + 4'd1;
                listo  <= estado == 4'd14;
                if (wr_l && estado == 4'd13) dato_leido <= bus_dato_in;
            end
        end
    end
    always_comb begin
        ocupado      = estado != 4'd15;
        W_R_out      = ocupado & wr_l;
        en_out       = ocupado & wr_l;
        fase_dir     = estado >= 4'd1 && estado <= 4'd9;
        fase_dat     = estado >= 4'd10 && estado <= 4'd14 && !wr_l;
        bus_oe       = fase_dir | fase_dat;
        bus_dato_out = fase_dir ? dir_l : fase_dat ? dat_l : 8'h00;
    end
endmodule
